// File: rtl/spi_pkg.sv
// Shared types and counter-width helpers for the parametrised SPI master.
package spi_pkg;

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

   typedef struct packed {
      logic cpol;
      logic cpha;
   } spi_mode_t;

   // Counts 0..2*data_w so the terminal value is representable without wrapping.
   function automatic int edge_cnt_w(input int data_w);
      return $clog2(2 * data_w + 1);
   endfunction

   function automatic int div_cnt_w(input int clk_div);
      return (clk_div > 1) ? $clog2(clk_div) : 1;
   endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK generator: half-period divider, leading/trailing edge strobes and the sclk register.
module spi_clk_gen
   import spi_pkg::*;
#(
   parameter int CLK_DIV = 4
)
(
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic shift,
   input  logic idle_lvl,
   output logic tick,
   output logic lead,
   output logic trail,
   output logic sclk
);

   localparam int            DW       = div_cnt_w(CLK_DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

   logic [DW-1:0] div_cnt;

   assign tick  = en && (div_cnt == DIV_LAST);
   // An edge is leading when sclk is about to leave its idle level.
   assign lead  = shift && tick && (sclk == idle_lvl);
   assign trail = shift && tick && (sclk != idle_lvl);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_cnt <= '0;
         sclk    <= 1'b0;
      end else begin
         if (!en || tick)
            div_cnt <= '0;
         else
            div_cnt <= div_cnt + 1'b1;

         if (!shift)
            sclk <= idle_lvl;
         else if (tick)
            sclk <= ~sclk;
      end
   end

endmodule

// File: rtl/spi_master_param.sv
// Full-duplex SPI master, per-transfer CPOL/CPHA, configurable width/divider/bit order.
// Define SPI_MASTER_LOOPBACK_EN to add the 'loopback' input (rx samples internal mosi).
module spi_master_param
   import spi_pkg::*;
#(
   parameter int DATA_W    = 12,
   parameter int CLK_DIV   = 4,
   parameter bit MSB_FIRST = 1'b1
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              cpol,
   input  logic              cpha,
   input  logic [DATA_W-1:0] din,
   input  logic              din_valid,
   output logic              din_ready,
   output logic [DATA_W-1:0] dout,
   output logic              done,
   output logic              busy,
   output logic              sclk,
   output logic              mosi,
   input  logic              miso,
   output logic              cs
`ifdef SPI_MASTER_LOOPBACK_EN
   ,
   input  logic              loopback
`endif
);

   localparam int            EW        = edge_cnt_w(DATA_W);
   localparam logic [EW-1:0] EDGE_LAST = EW'(2 * DATA_W - 1);

   state_t            state;
   spi_mode_t         mode_q;
   logic [EW-1:0]     edge_cnt;
   logic [DATA_W-1:0] tx_sr;
   logic [DATA_W-1:0] rx_sr;

   logic accept;
   logic idle_lvl;
   logic clk_en;
   logic in_shift;
   logic tick;
   logic lead;
   logic trail;
   logic last_edge;
   logic upd;
   logic smp;
   logic rx_bit;

   function automatic logic head(input logic [DATA_W-1:0] v);
      return MSB_FIRST ? v[DATA_W-1] : v[0];
   endfunction

   function automatic logic [DATA_W-1:0] adv(input logic [DATA_W-1:0] v);
      return MSB_FIRST ? {v[DATA_W-2:0], 1'b0} : {1'b0, v[DATA_W-1:1]};
   endfunction

   function automatic logic [DATA_W-1:0] ins(input logic [DATA_W-1:0] v, input logic b);
      return MSB_FIRST ? {v[DATA_W-2:0], b} : {b, v[DATA_W-1:1]};
   endfunction

   assign accept    = din_valid && din_ready;
   // The new cpol must reach sclk in the same edge that drops cs.
   assign idle_lvl  = accept ? cpol : mode_q.cpol;
   assign clk_en    = (state == SETUP) || (state == SHIFT) || (state == HOLD);
   assign in_shift  = (state == SHIFT);
   assign last_edge = (edge_cnt == EDGE_LAST);
   assign upd       = mode_q.cpha ? lead : (trail && !last_edge);
   assign smp       = mode_q.cpha ? trail : lead;

`ifdef SPI_MASTER_LOOPBACK_EN
   logic lb_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         lb_q <= 1'b0;
      else if (accept)
         lb_q <= loopback;
   end

   assign rx_bit = lb_q ? mosi : miso;
`else
   assign rx_bit = miso;
`endif

   spi_clk_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_clk_gen (
      .clk      (clk),
      .rst      (rst),
      .en       (clk_en),
      .shift    (in_shift),
      .idle_lvl (idle_lvl),
      .tick     (tick),
      .lead     (lead),
      .trail    (trail),
      .sclk     (sclk)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         mode_q    <= '0;
         edge_cnt  <= '0;
         cs        <= 1'b1;
         mosi      <= 1'b0;
         done      <= 1'b0;
         busy      <= 1'b0;
         din_ready <= 1'b1;
         dout      <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  state     <= SETUP;
                  mode_q    <= '{cpol: cpol, cpha: cpha};
                  edge_cnt  <= '0;
                  cs        <= 1'b0;
                  busy      <= 1'b1;
                  din_ready <= 1'b0;
                  // cpha=0 presents the first bit before the first sclk edge.
                  mosi      <= cpha ? 1'b0 : head(din);
               end
            end
            SETUP: begin
               if (tick)
                  state <= SHIFT;
            end
            SHIFT: begin
               if (tick) begin
                  edge_cnt <= edge_cnt + 1'b1;
                  if (last_edge)
                     state <= HOLD;
               end
               if (upd)
                  mosi <= head(tx_sr);
            end
            HOLD: begin
               if (tick) begin
                  state <= DONE;
                  cs    <= 1'b1;
                  done  <= 1'b1;
                  dout  <= rx_sr;
               end
            end
            DONE: begin
               state     <= IDLE;
               mosi      <= 1'b0;
               busy      <= 1'b0;
               din_ready <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // tx_sr always holds the next bit to present at its head.
   always_ff @(posedge clk) begin
      if (accept) begin
         tx_sr <= cpha ? din : adv(din);
         rx_sr <= '0;
      end else if (in_shift) begin
         if (upd)
            tx_sr <= adv(tx_sr);
         if (smp)
            rx_sr <= ins(rx_sr, rx_bit);
      end
   end

endmodule

// File: doc/spi_master_param.md
Name: spi_master_param

Overview:
- Parametrised successor to the fixed 12-bit, mode-0, MOSI-only SPI master/slave pair.
- Full-duplex SPI master: configurable word width, SCLK divider, all four CPOL/CPHA modes selected per transfer, optional MSB/LSB-first.
- Transmit word enters via valid/ready handshake; received MISO word is returned with a one-cycle valid strobe.
- Sits between the system-side controller and the external SPI pins.

Parameters:
- DATA_W, 12, bits per transfer (legal: >= 2).
- CLK_DIV, 4, clk cycles per SCLK half-period (legal: >= 1).
- MSB_FIRST, 1, 1 = MSB shifted first, 0 = LSB first.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpol  in  1  clock polarity; sampled at accept.
- cpha  in  1  clock phase; sampled at accept.
- din  in  DATA_W  transmit word.
- din_valid  in  1  transmit request.
- din_ready  out  1  high only in IDLE.
- dout  out  DATA_W  received word; held until next done.
- done  out  1  one-cycle pulse; dout valid this cycle.
- busy  out  1  high from accept until the cycle after done.
- sclk  out  1  SPI clock.
- mosi  out  1  serial data out.
- miso  in  1  serial data in.
- cs  out  1  active-low chip select.

Behaviour:
- Reset (rst=0, async): state IDLE; cs=1, sclk=0, mosi=0, done=0, busy=0, dout=0, din_ready=1 after release.
- Accept: din_valid & din_ready at rising edge t.
  - Latch din, cpol, cpha.
  - din_valid while not ready is ignored; no queuing.
- FSM transitions:
  - IDLE -> SETUP on accept.
  - SETUP: cs=0, sclk=cpol, CLK_DIV cycles.
  - SETUP -> SHIFT.
  - SHIFT: 2*DATA_W half-periods of CLK_DIV cycles each.
  - SHIFT -> HOLD: sclk=cpol, CLK_DIV cycles.
  - HOLD -> DONE.
  - DONE: cs=1, done=1, dout updated; single cycle.
  - DONE -> IDLE.
- SCLK: toggles at the end of each SHIFT half-period; idles at the latched cpol in every other state.
- cpha=0:
  - First bit on mosi from SETUP entry.
  - Sample miso on leading (odd) edges.
  - Update mosi on trailing edges, except after the last bit.
- cpha=1:
  - Update mosi on leading edges.
  - Sample miso on trailing edges.
- Bit order:
  - MSB_FIRST=1: tx shifts left, rx enters at bit 0.
  - MSB_FIRST=0: mirrored.
- mosi holds the last bit through HOLD and DONE, then returns to 0 in IDLE.
- Latency:
  - cs falls at t+1.
  - done at t+1+CLK_DIV*(2*DATA_W+2).
  - din_ready high again the following cycle; earliest back-to-back accept is that cycle.
- Counters:
  - Divider: $clog2(CLK_DIV) bits, wraps at CLK_DIV-1.
  - Edge counter: $clog2(2*DATA_W+1) bits, no wrap; terminal count ends SHIFT.
- cpol/cpha changes mid-transfer have no effect.
- Reset mid-transfer:
  - Immediate return to IDLE, cs=1, sclk=0.
  - No done; partial rx discarded; dout cleared to 0.

Optional Feature:
- Macro: SPI_MASTER_LOOPBACK_EN.
- Defined:
  - Adds input port loopback (1 bit, sampled at accept).
  - When latched high, the receive shifter samples internal mosi instead of miso, so dout == din after done.
  - External pins behave identically.
- Undefined: port absent; miso always used.

Decomposition:
- Package spi_pkg:
  - typedef enum state_t {IDLE, SETUP, SHIFT, HOLD, DONE}.
  - typedef struct spi_mode_t {cpol, cpha}.
  - Function for edge-counter width.
- Sub-module spi_clk_gen:
  - Divider counter and half-period tick.
  - Leading/trailing edge strobes, sclk register.
  - Used by the FSM/shift datapath in spi_master_param.

Test Plan (DATA_W=12, CLK_DIV=2 unless noted):
- Mode 0:
  - Stimulus: din=0xA5C accepted at cycle 0; slave model returns 0x3C1.
  - Response: cs low cycles 1-52; exactly 12 sclk rising edges; mosi decodes 0xA5C; done at cycle 53 with dout=0x3C1.
- Modes 1/2/3:
  - Stimulus: din=0x81F each mode, with a mode-matched slave model.
  - Response: sclk idles at cpol; sampling on correct edge; dout matches model word; no extra/missing edges.
- Back-to-back:
  - Stimulus: din_valid held with 0x001 then 0xFFF.
  - Response: second accept in the cycle after done; cs high for at least 1 cycle between words; both words correct.
- Busy ignore:
  - Stimulus: din_valid pulsed with 0x555 at cycle 10 of a transfer.
  - Response: ignored; din_ready=0; only the first word is transmitted.
- Reset mid-transfer:
  - Stimulus: rst=0 asynchronously at cycle 20.
  - Response: cs=1, sclk=0 immediately; no done; dout=0; next transfer of 0x123 completes correctly.
- MSB_FIRST=0, CLK_DIV=1, SPI_MASTER_LOOPBACK_EN:
  - Stimulus: din=0x6B2, loopback=1.
  - Response: LSB first on mosi; done at cycle 27; dout=0x6B2.
